// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared state encoding and default width for the restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_CALC = S_CALC,
        ST_DONE = S_DONE
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider_if
// Purpose  : Operand/result valid-ready bundle for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_restoring_divider_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division step (shift in, trial subtract).
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH:0]   r,
    input  wire logic             next_bit,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH:0]   r_next,
    output logic                  q_bit
);
    logic [WIDTH+1:0] w_trial;
    logic [WIDTH+1:0] w_diff;

    // r[WIDTH] is always 0 between steps, so the extra top bit only exposes
    // the borrow of the trial subtract: a set MSB means T < divisor.
    assign w_trial = {r, next_bit};
    assign w_diff  = w_trial - {2'b00, divisor};
    assign q_bit   = ~w_diff[WIDTH+1];
    assign r_next  = q_bit ? w_diff[WIDTH:0] : {r[WIDTH-1:0], next_bit};
endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider
// Purpose  : Sequential unsigned 2W/W restoring divider, one quotient bit/clock.
// Revision : 1.0 - initial release
// ============================================================================
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    seq_restoring_divider_if.slave  bus
);
    localparam int                  CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]    c_cnt_init  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]    c_sat_quot  = {WIDTH{1'b1}};

    div_state_t         r_state;
    div_state_t         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_div;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dz;
    logic               r_ovf;

    logic               w_accept;
    logic               w_err_dz;
    logic               w_err_ovf;
    logic [WIDTH:0]     w_r_next;
    logic               w_q_bit;

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_err_dz  = (bus.divisor == '0);
    // A high half at or above the divisor means the quotient needs > WIDTH bits.
    assign w_err_ovf = !w_err_dz && (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);

    div_step #(.WIDTH(WIDTH)) u_step (
        .r        (r_rem),
        .next_bit (r_q[WIDTH-1]),
        .divisor  (r_div),
        .r_next   (w_r_next),
        .q_bit    (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_err_dz || w_err_ovf) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_div <= bus.divisor;
                        r_rem <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
                        r_q   <= bus.dividend[WIDTH-1:0];
                        r_cnt <= c_cnt_init;
                        r_dz  <= w_err_dz;
                        r_ovf <= w_err_ovf;
                        if (w_err_dz || w_err_ovf) begin
                            r_quotient  <= c_sat_quot;
                            r_remainder <= bus.dividend[WIDTH-1:0];
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_r_next;
                    r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_quotient  <= {r_q[WIDTH-2:0], w_q_bit};
                        r_remainder <= w_r_next[WIDTH-1:0];
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == ST_IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dz;
    assign bus.overflow    = r_ovf;
endmodule
`default_nettype wire
